data_mem_lsu: RTL and testbench

Load/store initiator that drives the word-only 16384x32 data memory port (addr, writeData, MemWrite, MemRead, readData) on behalf of the MIPS pipeline. It accepts one byte, halfword or word request at a time over a valid/ready handshake and issues the memory strobes. Sub-word stores are done as read-modify-write. Loads are aligned, lane-extracted and sign/zero-extended before return on a single-cycle response pulse.

---
 rtl/data_mem_lsu.sv | 135 +++++++++++++
 tb/tb_data_mem_lsu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte/half/word load-store initiator for the word-only data memory
module data_mem_lsu #(
  parameter int unsigned RD_LAT     = 1,
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_writeData,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_readData
);

  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t        state, nextState;
  logic [CW-1:0] cnt;
  logic          opWe, opUns, opFault;
  logic [1:0]    opSize, opOff;
  logic [31:0]   opWdata;

  logic          accept, reqFault;
  logic [4:0]    laneShift;
  logic [31:0]   laneMask, mergedWord, laneWord, loadData;

  assign accept   = req_valid & req_ready;
  assign reqFault = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                    (req_addr >= ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState    = state;
    req_ready    = 1'b0;
    mem_MemRead  = 1'b0;
    mem_MemWrite = 1'b0;
    rsp_valid    = 1'b0;
    rsp_fault    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~reset;
        if (accept) begin
          if (reqFault)               nextState = RESP;
          else if (!req_we)           nextState = RD;
          else if (req_size == 2'b10) nextState = WR;
          else                        nextState = RD;
        end
      end
      RD: begin
        mem_MemRead = 1'b1;
        if (cnt == '0) nextState = opWe ? WR : RESP;
      end
      WR: begin
        mem_MemWrite = 1'b1;
        nextState    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_fault = opFault;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Big-endian lanes: byte offset 0 and half offset 0 sit in the top bits.
  always_comb begin
    laneShift = 5'd0;
    laneMask  = 32'hFFFF_FFFF;
    if (opSize == 2'b00) begin
      laneShift = {~opOff, 3'b000};
      laneMask  = 32'h0000_00FF << laneShift;
    end else if (opSize == 2'b01) begin
      laneShift = {~opOff[1], 4'b0000};
      laneMask  = 32'h0000_FFFF << laneShift;
    end
    mergedWord = (mem_readData & ~laneMask) | ((opWdata << laneShift) & laneMask);
    laneWord   = mem_readData >> laneShift;
    case (opSize)
      2'b00:   loadData = opUns ? {24'b0, laneWord[7:0]}  : {{24{laneWord[7]}}, laneWord[7:0]};
      2'b01:   loadData = opUns ? {16'b0, laneWord[15:0]} : {{16{laneWord[15]}}, laneWord[15:0]};
      default: loadData = mem_readData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      opWe          <= 1'b0;
      opUns         <= 1'b0;
      opFault       <= 1'b0;
      opSize        <= 2'b00;
      opOff         <= 2'b00;
      opWdata       <= 32'b0;
      mem_addr      <= 32'b0;
      mem_writeData <= 32'b0;
      rsp_rdata     <= 32'b0;
    end else if (accept) begin
      cnt           <= CW'(RD_LAT);
      opWe          <= req_we;
      opUns         <= req_unsigned;
      opFault       <= reqFault;
      opSize        <= req_size;
      opOff         <= req_addr[1:0];
      opWdata       <= req_wdata;
      mem_addr      <= {16'b0, req_addr[15:2], 2'b00};
      mem_writeData <= (req_we && req_size == 2'b10 && !reqFault) ? req_wdata : 32'b0;
      rsp_rdata     <= 32'b0;
    end else if (state == RD) begin
      // The memory word is sampled only on the edge that ends the last RD cycle.
      if (cnt != '0)  cnt           <= cnt - CW'(1);
      else if (opWe)  mem_writeData <= mergedWord;
      else            rsp_rdata     <= loadData;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - randomized scoreboard bench for data_mem_lsu
module tb_data_mem_lsu;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_writeData, mem_readData;
  logic        mem_MemWrite, mem_MemRead;

  data_mem_lsu #(.RD_LAT(RD_LAT), .ADDR_LIMIT(32'h0001_0000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_addr(mem_addr), .mem_writeData(mem_writeData),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  logic [31:0] mem [0:16383];
  logic [31:0] rdq;
  assign mem_readData = rdq;
  always @(posedge clk) begin
    if (mem_MemWrite) mem[mem_addr[15:2]] <= mem_writeData;
    rdq <= mem[mem_addr[15:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          respCyc;
    int          nRd;
    int          nWr;
    logic        chkMem;
    int          widx;
    logic [31:0] word;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] refMem [0:16383];

  // Reference: what a byte-addressed big-endian memory should do for each request.
  task automatic pushExp(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int acc);
    exp_t        e;
    int          idx, o;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    idx = int'(addr[15:2]);
    o   = int'(addr[1:0]);
    e.rdata = 0; e.fault = 0; e.nRd = 0; e.nWr = 0; e.chkMem = 0; e.widx = idx; e.word = 0;
    if (size == 2'd3 || (size == 2'd1 && o % 2 != 0) || (size == 2'd2 && o != 0) ||
        addr >= 32'h0001_0000) begin
      e.fault   = 1;
      e.respCyc = acc + 1;
    end else if (!we) begin
      w = refMem[idx];
      if (size == 2'd0) begin
        b = w[8*(3-o) +: 8];
        e.rdata = uns ? {24'b0, b} : {{24{b[7]}}, b};
      end else if (size == 2'd1) begin
        h = w[16*(1-o/2) +: 16];
        e.rdata = uns ? {16'b0, h} : {{16{h[15]}}, h};
      end else begin
        e.rdata = w;
      end
      e.nRd     = RD_LAT + 1;
      e.respCyc = acc + RD_LAT + 2;
    end else begin
      w = refMem[idx];
      if (size == 2'd2) begin
        w = wdata;
        e.respCyc = acc + 2;
      end else begin
        if (size == 2'd0) w[8*(3-o) +: 8] = wdata[7:0];
        else              w[16*(1-o/2) +: 16] = wdata[15:0];
        e.nRd     = RD_LAT + 1;
        e.respCyc = acc + RD_LAT + 3;
      end
      e.nWr       = 1;
      refMem[idx] = w;
      e.chkMem    = 1;
      e.word      = w;
    end
    sbq.push_back(e);
  endtask

  task automatic doReq(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic track, output int acc);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = -1;
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready stayed 0 for addr %h", addr);
    end else begin
      acc = cyc;
      if (track) pushExp(we, size, uns, addr, wdata, acc);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: strobe accounting and response checking, independent of stimulus.
  int rdCnt = 0, wrCnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      rdCnt = 0;
      wrCnt = 0;
    end else begin
      if (mem_MemRead)  rdCnt++;
      if (mem_MemWrite) wrCnt++;
      if (mem_MemRead || mem_MemWrite) chk("strobe_overlap", {31'b0, mem_MemRead & mem_MemWrite}, 32'd0);
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: rsp_valid with empty scoreboard at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
          chk("rsp_cycle", 32'(cyc), 32'(e.respCyc));
          chk("memread_cycles", 32'(rdCnt), 32'(e.nRd));
          chk("memwrite_cycles", 32'(wrCnt), 32'(e.nWr));
          if (e.chkMem) chk("mem_word", mem[e.widx], e.word);
        end
        rdCnt = 0;
        wrCnt = 0;
      end
    end
  end

  initial begin
    int a1, a2;
    logic [31:0] ad;
    for (int i = 0; i < 16384; i++) begin
      mem[i]    <= 32'b0;
      refMem[i] =  32'b0;
    end
    reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_strobes", {30'b0, mem_MemRead, mem_MemWrite}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_writeData, 32'd0);
    reset = 0;

    doReq(1, 2'd2, 0, 32'h0, 32'h1, 1, a1);
    doReq(1, 2'd2, 0, 32'h4, 32'habc, 1, a1);
    doReq(0, 2'd2, 0, 32'h4, 32'h0, 1, a1);
    doReq(1, 2'd2, 0, 32'hc008, 32'hcba, 1, a1);
    doReq(1, 2'd0, 0, 32'hc009, 32'hA5, 1, a1);
    doReq(0, 2'd2, 0, 32'hc008, 32'h0, 1, a1);
    idle(2);
    chk("sb_merge_word", mem[32'hc008 >> 2], 32'h00A50cba);
    doReq(0, 2'd0, 0, 32'hc009, 0, 1, a1);
    doReq(0, 2'd0, 1, 32'hc009, 0, 1, a1);
    doReq(0, 2'd1, 0, 32'hc00a, 0, 1, a1);
    doReq(0, 2'd1, 1, 32'hc008, 0, 1, a1);
    doReq(0, 2'd1, 0, 32'h1, 0, 1, a1);
    doReq(1, 2'd2, 0, 32'h6, 32'hdead, 1, a1);
    doReq(0, 2'd2, 0, 32'h0001_0000, 0, 1, a1);
    doReq(1, 2'd3, 0, 32'h0, 32'hffff, 1, a1);
    doReq(0, 2'd2, 0, 32'h0, 0, 1, a1);

    // Reset during the RD cycle of a byte store: request must vanish.
    doReq(1, 2'd2, 0, 32'h8, 32'h12345678, 1, a1);
    doReq(1, 2'd0, 0, 32'h8, 32'h55, 0, a1);
    @(negedge clk);
    chk("abort_in_rd", {31'b0, mem_MemRead}, 32'd1);
    reset = 1; req_valid = 0;
    @(negedge clk);
    chk("abort_strobes", {30'b0, mem_MemRead, mem_MemWrite}, 32'd0);
    chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    reset = 0;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_mem_kept", mem[2], 32'h12345678);
    doReq(0, 2'd2, 0, 32'h8, 0, 1, a1);

    // Back-to-back with req_valid held high.
    doReq(1, 2'd2, 0, 32'h8, 32'hcafef00d, 1, a1);
    doReq(0, 2'd2, 0, 32'h8, 0, 1, a2);
    chk("b2b_accept_cycle", 32'(a2), 32'(a1 + 3));

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) ad = 32'h0001_0000 + $urandom_range(0, 255);
      else                           ad = $urandom_range(0, 31);
      doReq(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ad, $urandom, 1, a1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end

    idle(12);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
